addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised, multi-cycle two's-complement adder/subtractor. It processes a WIDTH-bit operation CHUNK bits per clock, LSB chunk first, through a single CHUNK-bit ripple slice. It extends the team's combinational 8-bit add/sub to arbitrary widths with a start/done handshake and status flags. It sits in the datapath wherever area matters more than latency.

## Interface
- WIDTH, default 16: operand and result width; must be ≥ 2.
- CHUNK, default 4: bits processed per cycle; must divide WIDTH. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; accepted only when ready=1.
- ready  out  1  high when idle and able to accept start.
- a  in  WIDTH  first operand; sampled at the acceptance edge only.
- b  in  WIDTH  second operand; sampled at the acceptance edge only.
- sub  in  1  0 selects a+b; 1 selects a−b. Sampled at the acceptance edge.
- done  out  1  one-cycle pulse when the result and flags become valid.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- zero  out  1  result == 0.

## Operation
- States are IDLE and RUN. ready = (state == IDLE).
- **IDLE, start=1:** at this edge (the acceptance edge) latch a and b. If sub=1, latch ~b. Set carry = sub, count = 0, state = RUN.
- **RUN, each edge:** add operand chunk `count` of a, chunk `count` of the latched b, and the carry. Write the sum chunk into the result register and save the carry out.
  - On the chunk with index N−1, also capture the MSB carry-in (for ovf). Update cout, ovf and zero, return to IDLE, and assert done for the following cycle.
- **Otherwise:** count increments.
- start while in RUN is ignored and has no side effects.
- a, b and sub may change freely after the acceptance edge.
- result, cout, ovf and zero hold their last values until the completion edge of the next operation.
  - They are not disturbed while an operation is in progress. Use a separate working register, or update the output register only at completion.
- Arithmetic is unsigned modulo 2^WIDTH. The flags allow both signed and unsigned interpretation.

## Timing
- **Reset:** state = IDLE, ready=1, done=0, result=0, cout=0, ovf=0, zero=1, count=0.
- **Reset during RUN:** abort the operation immediately. No done pulse is produced; all outputs take their reset values.
- **Latency:** with the acceptance edge as edge 0, the completion edge is edge N.
  - done=1 and the outputs are valid in the cycle after edge N.
  - ready returns to 1 in that same cycle.
- **Back-to-back:** start=1 in the done cycle is accepted. Sustained throughput is one operation every N+1 cycles.
- **CHUNK = WIDTH:** N=1, so done follows the acceptance by exactly one completion edge. There is no special-case logic.
- **start together with rst:** rst wins; the operation is not accepted.
- done is never asserted for two consecutive cycles.

## Structure
- The shared package holds the state enumeration (IDLE, RUN).
- It also holds a localparam helper for N and for the count width, $clog2(N), minimum 1.
- One sub-module, addsub_chunk: a combinational CHUNK-bit ripple adder.
  - Inputs: x, y, cin.
  - Outputs: s, cout, and c_msb_in (the carry into bit CHUNK−1).
  - Reused across cycles.
- The top level holds the FSM, the counter, the operand shift/select and the flag logic.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- Add 0x1234 + 0x0FED → result=0x2221, cout=0, ovf=0, zero=0. done is seen exactly 4 edges after acceptance.
- Sub 0x0005 − 0x0007 → result=0xFFFE, cout=0 (borrow), ovf=0. Sub 0x8000 − 0x0001 → result=0x7FFF, cout=1, ovf=1.
- Add 0x7FFF + 0x0001 → result=0x8000, ovf=1, cout=0. Add 0xFFFF + 0x0001 → result=0x0000, cout=1, zero=1.
- Interference: pulse start again in the cycle after acceptance, and change a, b and sub mid-run. The first result must be unaffected, and only one done is produced.
- Reset mid-RUN at edge 2, then release:
  - all outputs must show reset values, with no done;
  - a new start must complete correctly.
- Back-to-back: issue start in each done cycle for 4 random operations, checked against a behavioural model.
- Repeat the random test with WIDTH=8, CHUNK=8 (N=1) and with WIDTH=32, CHUNK=1.

Source files
------------

// File: rtl/addsub_serial_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder/subtractor.
package addsub_serial_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int unsigned num_chunks(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk counter width; never narrower than one bit even when a single chunk covers the word.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice, reused once per cycle by the serial top.
module addsub_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]     = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement add/sub: WIDTH bits processed CHUNK bits per clock, LSB chunk first.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = num_chunks(WIDTH, CHUNK);
  localparam int unsigned CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_result;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;
  logic              r_done;
  logic              r_ready;

  logic [31:0]       w_base;
  logic [CHUNK-1:0]  w_x;
  logic [CHUNK-1:0]  w_y;
  logic [CHUNK-1:0]  w_s;
  logic              w_cout;
  logic              w_c_msb;
  logic [WIDTH-1:0]  w_acc_nxt;
  logic              w_accept;
  logic              w_last;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST_CNT);
  assign w_base   = 32'(r_cnt) * CHUNK;
  assign w_x      = CHUNK'(r_a >> w_base);
  assign w_y      = CHUNK'(r_b >> w_base);

  addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x        (w_x),
    .y        (w_y),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_c_msb)
  );

  // Working result with the current chunk merged in; on the last chunk this is the full answer.
  assign w_acc_nxt = (r_acc & ~(WIDTH'({CHUNK{1'b1}}) << w_base)) | (WIDTH'(w_s) << w_base);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, chunk iteration and completion-only update of visible results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_done  <= w_last;
      r_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_acc   <= w_acc_nxt;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_cnt    <= '0;
          r_result <= w_acc_nxt;
          r_cout   <= w_cout;
          r_ovf    <= w_c_msb ^ w_cout;
          r_zero   <= (w_acc_nxt == '0);
        end
      end
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial in three geometries: 16/4, 8/8 and 32/1.
module tb_addsub_serial;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        sub_in;
  logic [2:0]  ready, done, cout, ovf, zero;
  logic [15:0] res0;
  logic [7:0]  res1;
  logic [31:0] res2;
  logic [31:0] last_res [3];

  int n_vec = 0;
  int n_err = 0;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) u_w16 (
    .clk(clk), .rst(rst), .start(start[0]), .ready(ready[0]), .a(a_in[15:0]), .b(b_in[15:0]),
    .sub(sub_in), .done(done[0]), .result(res0), .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0]));

  addsub_serial #(.WIDTH(8), .CHUNK(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start[1]), .ready(ready[1]), .a(a_in[7:0]), .b(b_in[7:0]),
    .sub(sub_in), .done(done[1]), .result(res1), .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1]));

  addsub_serial #(.WIDTH(32), .CHUNK(1)) u_w32 (
    .clk(clk), .rst(rst), .start(start[2]), .ready(ready[2]), .a(a_in), .b(b_in),
    .sub(sub_in), .done(done[2]), .result(res2), .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2]));

  function automatic logic [31:0] res_of(input int k);
    case (k)
      0:       return {16'd0, res0};
      1:       return {24'd0, res1};
      default: return res2;
    endcase
  endfunction

  function automatic int width_of(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 8 : 32);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: wide integer add, overflow from operand/result sign agreement.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s, input int w,
                       output logic [31:0] r, output logic c, output logic v, output logic z);
    logic [63:0] mask, aa, bb, sum;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
    sum  = aa + bb + {63'd0, s};
    r    = 32'(sum & mask);
    c    = sum[w];
    v    = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    z    = (r == 32'd0);
  endtask

  task automatic check_reset_state(input int k, input string tag);
    check({tag, "_ready"},  32'(ready[k]), 32'd1);
    check({tag, "_done"},   32'(done[k]),  32'd0);
    check({tag, "_result"}, res_of(k),     32'd0);
    check({tag, "_cout"},   32'(cout[k]),  32'd0);
    check({tag, "_ovf"},    32'(ovf[k]),   32'd0);
    check({tag, "_zero"},   32'(zero[k]),  32'd1);
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    a_in     = a;
    b_in     = b;
    sub_in   = s;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    check("ready_after_accept", 32'(ready[k]), 32'd0);
    check("done_after_accept",  32'(done[k]),  32'd0);
  endtask

  // Counts edges after acceptance until done; results must hold their old value meanwhile.
  task automatic wait_done(input int k, input string tag);
    int lat;
    lat = 0;
    for (int i = 0; i < lat_of(k) + 5; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done[k]) break;
      check({tag, "_hold"}, res_of(k), last_res[k]);
    end
    check({tag, "_latency"}, 32'(lat), 32'(lat_of(k)));
    check({tag, "_ready_at_done"}, 32'(ready[k]), 32'd1);
  endtask

  task automatic run_op(input int k, input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] er, input logic ec, input logic ev,
                        input logic ez);
    issue(k, a, b, s);
    wait_done(k, tag);
    check({tag, "_result"}, res_of(k), er);
    check({tag, "_cout"},   32'(cout[k]), 32'(ec));
    check({tag, "_ovf"},    32'(ovf[k]),  32'(ev));
    check({tag, "_zero"},   32'(zero[k]), 32'(ez));
    last_res[k] = er;
  endtask

  task automatic run_random(input int k, input string tag);
    logic [31:0] ra, rb, er;
    logic        rs, ec, ev, ez;
    ra = $urandom;
    rb = $urandom;
    rs = 1'($urandom_range(0, 1));
    model(ra, rb, rs, width_of(k), er, ec, ev, ez);
    run_op(k, tag, ra, rb, rs, er, ec, ev, ez);
  endtask

  initial begin
    int ndone;
    int at;
    logic [31:0] seen;

    rst    = 1'b1;
    start  = 3'b000;
    a_in   = '0;
    b_in   = '0;
    sub_in = 1'b0;
    for (int k = 0; k < 3; k++) last_res[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state(0, "rst16");
    check_reset_state(1, "rst8");
    check_reset_state(2, "rst32");

    // Hand-computed corner cases, issued back-to-back in each done cycle.
    run_op(0, "add_1234_0fed", 32'h1234, 32'h0FED, 1'b0, 32'h2221, 1'b0, 1'b0, 1'b0);
    run_op(0, "sub_5_7",       32'h0005, 32'h0007, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(0, "sub_8000_1",    32'h8000, 32'h0001, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(0, "add_7fff_1",    32'h7FFF, 32'h0001, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0);
    run_op(0, "add_ffff_1",    32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1);

    // Second start pulse and input churn during RUN must not disturb the first operation.
    issue(0, 32'h1111, 32'h2222, 1'b0);
    start[0] = 1'b1;
    a_in     = 32'hFFFF;
    b_in     = 32'h0001;
    sub_in   = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    a_in     = 32'h0;
    b_in     = 32'hABCD;
    ndone    = 0;
    at       = 0;
    seen     = '0;
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk); #1;
      if (done[0]) begin
        ndone++;
        at   = i;
        seen = res_of(0);
      end
    end
    check("intf_done_count", 32'(ndone), 32'd1);
    check("intf_done_edge",  32'(at),    32'd4);
    check("intf_result",     seen,       32'h3333);
    last_res[0] = 32'h3333;

    // Reset sampled at edge 2 of a running operation.
    issue(0, 32'h0101, 32'h0202, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state(0, "midrst");
    last_res[0] = '0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done[0]) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_op(0, "after_rst", 32'h00F0, 32'h0F0F, 1'b0, 32'h0FFF, 1'b0, 1'b0, 1'b0);

    // start coincident with reset is dropped.
    rst      = 1'b1;
    start[0] = 1'b1;
    a_in     = 32'h0005;
    b_in     = 32'h0005;
    @(posedge clk); #1;
    rst      = 1'b0;
    start[0] = 1'b0;
    last_res[0] = '0;
    check("rststart_ready", 32'(ready[0]), 32'd1);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done[0] || !ready[0]) ndone++;
    end
    check("rststart_idle", 32'(ndone), 32'd0);

    // Back-to-back random operations against the reference model, all geometries.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) run_random(k, $sformatf("rand_w%0d_%0d", width_of(k), j));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
